// File: rtl/accel_sequencer_if.sv
// Command/response bundle between the ADXL345 sequencer (master) and the
// I2C byte-transaction controller (slave).
interface accel_sequencer_if;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic       i2c_r_w;
    logic [7:0] i2c_write_data;
    logic [7:0] i2c_read_data;
    logic       i2c_start;
    logic       i2c_finished;
    logic       i2c_ready;

    modport master (
        output i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data, i2c_start,
        input  i2c_read_data, i2c_finished, i2c_ready
    );

    modport slave (
        input  i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data, i2c_start,
        output i2c_read_data, i2c_finished, i2c_ready
    );
endinterface

// File: rtl/accel_sequencer.sv
// Configures the ADXL345 over the I2C byte controller, then reads X/Y/Z
// once per sample period and publishes them with a one-cycle strobe.
module accel_sequencer #(
    parameter int         SYS_CLK_SPEED  = 50000000,
    parameter int         SAMPLE_RATE_HZ = 100,
    parameter int         STARTUP_CYCLES = 500000,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_RETRIES    = 2,
    parameter logic [6:0] ACCEL_ADDR     = 7'h1D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    accel_sequencer_if.master   i2c,
    output logic signed [15:0]  accel_x,
    output logic signed [15:0]  accel_y,
    output logic signed [15:0]  accel_z,
    output logic                sample_valid,
    output logic                config_done,
    output logic                error,
    output logic                overrun
);
    localparam int SAMPLE_PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
    localparam int CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(SAMPLE_PERIOD + 1);
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        ST_STARTUP, ST_CFG_ISSUE, ST_CFG_WAIT, ST_SAMPLE_WAIT,
        ST_RD_ISSUE, ST_RD_WAIT, ST_PUBLISH, ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [2:0]         idx_q, idx_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic               fin_prev_q, pend_q, pend_d;
    logic [7:0]         reg_q, reg_d, wd_q, wd_d;
    logic               rw_q, rw_d, start_q, start_d;
    logic signed [15:0] ax_q, ay_q, az_q;
    logic               valid_q, valid_d, cfg_done_q, cfg_done_d;
    logic               err_q, err_d, ovr_q, ovr_d;
    logic [5:0][7:0]    slot_q;
    logic               slot_we, done, timeout, wrap;

    // Completion is an edge, so a finished level left over from the previous
    // transaction (or from before reset) never completes a new one.
    assign done    = i2c.i2c_finished & ~fin_prev_q;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign wrap    = cfg_done_q && (per_q == PER_W'(SAMPLE_PERIOD - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        idx_d      = idx_q;
        rty_d      = rty_q;
        pend_d     = pend_q;
        reg_d      = reg_q;
        wd_d       = wd_q;
        rw_d       = rw_q;
        start_d    = 1'b0;
        valid_d    = 1'b0;
        cfg_done_d = cfg_done_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        slot_we    = 1'b0;

        if (cfg_done_q) per_d = wrap ? '0 : per_q + PER_W'(1);
        if (wrap && (state_q == ST_RD_ISSUE || state_q == ST_RD_WAIT || state_q == ST_PUBLISH)) begin
            ovr_d  = 1'b1;
            pend_d = 1'b1;
        end

        case (state_q)
            ST_STARTUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CFG_ISSUE;
                end
            end
            ST_CFG_ISSUE: begin
                if (i2c.i2c_ready) begin
                    reg_d   = idx_q[0] ? 8'h2D : 8'h31;
                    wd_d    = 8'h08;
                    rw_d    = 1'b0;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CFG_WAIT;
                end
            end
            ST_CFG_WAIT, ST_RD_WAIT: begin
                if (done) begin
                    rty_d = '0;
                    if (state_q == ST_CFG_WAIT) begin
                        if (idx_q[0]) begin
                            idx_d      = '0;
                            cfg_done_d = 1'b1;
                            per_d      = '0;
                            state_d    = ST_SAMPLE_WAIT;
                        end else begin
                            idx_d   = 3'd1;
                            state_d = ST_CFG_ISSUE;
                        end
                    end else begin
                        slot_we = 1'b1;
                        if (idx_q == 3'd5) begin
                            state_d = ST_PUBLISH;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = ST_RD_ISSUE;
                        end
                    end
                end else if (timeout) begin
                    // Retry re-issues the same list entry; idx is left untouched.
                    if (rty_q < RTY_W'(MAX_RETRIES)) begin
                        rty_d   = rty_q + RTY_W'(1);
                        state_d = (state_q == ST_CFG_WAIT) ? ST_CFG_ISSUE : ST_RD_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE_WAIT: begin
                if ((wrap || pend_q) && enable) begin
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (i2c.i2c_ready) begin
                    reg_d   = 8'h32 + {5'b0, idx_q};
                    rw_d    = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_PUBLISH: begin
                valid_d = 1'b1;
                state_d = ST_SAMPLE_WAIT;
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STARTUP;
            cnt_q      <= '0;
            per_q      <= '0;
            idx_q      <= '0;
            rty_q      <= '0;
            fin_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            reg_q      <= '0;
            wd_q       <= '0;
            rw_q       <= 1'b0;
            start_q    <= 1'b0;
            ax_q       <= '0;
            ay_q       <= '0;
            az_q       <= '0;
            valid_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            idx_q      <= idx_d;
            rty_q      <= rty_d;
            fin_prev_q <= i2c.i2c_finished;
            pend_q     <= pend_d;
            reg_q      <= reg_d;
            wd_q       <= wd_d;
            rw_q       <= rw_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            if (state_q == ST_PUBLISH) begin
                ax_q <= {slot_q[1], slot_q[0]};
                ay_q <= {slot_q[3], slot_q[2]};
                az_q <= {slot_q[5], slot_q[4]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (slot_we) slot_q[idx_q] <= i2c.i2c_read_data;
    end

    assign i2c.i2c_dev_addr   = ACCEL_ADDR;
    assign i2c.i2c_reg_addr   = reg_q;
    assign i2c.i2c_r_w        = rw_q;
    assign i2c.i2c_write_data = wd_q;
    assign i2c.i2c_start      = start_q;
    assign accel_x            = ax_q;
    assign accel_y            = ay_q;
    assign accel_z            = az_q;
    assign sample_valid       = valid_q;
    assign config_done        = cfg_done_q;
    assign error              = err_q;
    assign overrun            = ovr_q;
endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer with a behavioural I2C controller model.
module tb_accel_sequencer;
    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic signed [15:0] accel_x, accel_y, accel_z;
    logic               sample_valid, config_done, error, overrun;

    accel_sequencer_if bus();

    accel_sequencer #(
        .SYS_CLK_SPEED (1000),
        .SAMPLE_RATE_HZ(10),
        .STARTUP_CYCLES(20),
        .TIMEOUT_CYCLES(50),
        .MAX_RETRIES   (2),
        .ACCEL_ADDR    (7'h1D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .i2c         (bus),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .sample_valid(sample_valid),
        .config_done (config_done),
        .error       (error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rg;
        logic       rw;
        logic [7:0] wd;
        int         cyc;
        logic       fin;
    } start_t;

    typedef struct {
        logic [47:0] bytes;   // byte for register 0x32+i in bits [8*i +: 8]
        logic [15:0] x, y, z;
    } vec_t;

    start_t     slog[$];
    logic [7:0] mem [6];
    int         delay_cfg, ign_limit, ign_done, clr_req, clr_ack;
    logic [7:0] ign_reg;
    bit         force_busy;
    int         cyc, chg_err, pulse_err;
    int         tests, fails;

    // Controller model: completes delay_cfg cycles after a start, keeps finished
    // high until the next start, and can silently drop starts for ign_reg.
    initial begin
        bit         busy;
        bit         prev_start;
        int         cd;
        int         k;
        logic [7:0] cur_reg;
        logic [47:0] prev_acc;
        start_t     e;
        busy = 0; prev_start = 0; cd = 0; cur_reg = 0; prev_acc = '0;
        cyc = 0; chg_err = 0; pulse_err = 0; ign_done = 0; clr_ack = 0;
        bus.i2c_read_data = 8'h00;
        bus.i2c_finished  = 1'b0;
        bus.i2c_ready     = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_ack != clr_req) begin
                clr_ack = clr_req;
                busy = 0;
                bus.i2c_finished = 1'b0;
            end
            if (bus.i2c_start) begin
                e.rg = bus.i2c_reg_addr; e.rw = bus.i2c_r_w; e.wd = bus.i2c_write_data;
                e.cyc = cyc; e.fin = bus.i2c_finished;
                slog.push_back(e);
                if (prev_start) pulse_err++;
                if (bus.i2c_reg_addr == ign_reg && ign_done < ign_limit) begin
                    ign_done++;
                end else begin
                    busy = 1; cd = delay_cfg; cur_reg = bus.i2c_reg_addr;
                    bus.i2c_finished = 1'b0;
                end
            end else if (busy) begin
                cd--;
                if (cd <= 0) begin
                    busy = 0;
                    bus.i2c_finished = 1'b1;
                    k = int'(cur_reg) - 'h32;
                    bus.i2c_read_data = (k >= 0 && k < 6) ? mem[k] : 8'h00;
                end
            end
            prev_start    = bus.i2c_start;
            bus.i2c_ready = !busy && !force_busy;
            if (!rst && !sample_valid && {accel_x, accel_y, accel_z} != prev_acc) chg_err++;
            prev_acc = {accel_x, accel_y, accel_z};
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit clr_model);
        rst = 1'b1;
        if (clr_model) clr_req++;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic load_mem(input logic [47:0] b);
        for (int i = 0; i < 6; i++) mem[i] = b[8*i +: 8];
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sample_valid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_cfg(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (config_done) begin ok = 1; break; end
        end
    endtask

    task automatic wait_start(input logic [7:0] rg, input int bound, output bit ok, output int n);
        ok = 0; n = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.i2c_start && bus.i2c_reg_addr == rg) begin ok = 1; break; end
            n++;
        end
    endtask

    task automatic wait_logged(input int base, input logic [7:0] rg, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            for (int j = base; j < slog.size(); j++) if (slog[j].rg == rg) ok = 1;
        end
    endtask

    function automatic int count_reg(input int base, input logic [7:0] rg);
        int c = 0;
        for (int j = base; j < slog.size(); j++) if (slog[j].rg == rg) c++;
        return c;
    endfunction

    function automatic logic [7:0] log_reg(input int k);
        return (k < slog.size()) ? slog[k].rg : 8'h00;
    endfunction

    function automatic logic log_fin(input int k);
        return (k < slog.size()) ? slog[k].fin : 1'b0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   n, base, n32, bad, last, sz;
        tests = 0; fails = 0; clr_req = 0;
        rst = 1'b1; enable = 1'b1; force_busy = 0;
        delay_cfg = 30; ign_reg = 8'h00; ign_limit = 0;
        vecs[0] = '{48'h0100FFFF1234, 16'h1234, 16'hFFFF, 16'h0100};
        vecs[1] = '{48'h00017FFF8000, 16'h8000, 16'h7FFF, 16'h0001};
        vecs[2] = '{48'hFFFE0000A55A, 16'hA55A, 16'h0000, 16'hFFFE};
        vecs[3] = '{48'h060504030201, 16'h0201, 16'h0403, 16'h0605};

        // Reset state, startup latency and configuration writes
        load_mem(vecs[0].bytes);
        do_reset(1);
        check("rst_accel_x", $unsigned(accel_x), 0);
        check("rst_accel_y", $unsigned(accel_y), 0);
        check("rst_accel_z", $unsigned(accel_z), 0);
        check("rst_valid", sample_valid, 0);
        check("rst_config_done", config_done, 0);
        check("rst_error", error, 0);
        check("rst_overrun", overrun, 0);
        check("rst_start", bus.i2c_start, 0);
        check("rst_r_w", bus.i2c_r_w, 0);
        check("rst_reg_addr", bus.i2c_reg_addr, 0);
        check("rst_write_data", bus.i2c_write_data, 0);
        check("dev_addr", bus.i2c_dev_addr, 7'h1D);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.i2c_start) break;
            n++;
        end
        check("startup_latency", n, 20);
        check("cfg0_reg", bus.i2c_reg_addr, 8'h31);
        check("cfg0_data", bus.i2c_write_data, 8'h08);
        check("cfg0_r_w", bus.i2c_r_w, 0);
        wait_start(8'h2D, 200, ok, n);
        check("cfg1_seen", ok, 1);
        check("cfg1_data", bus.i2c_write_data, 8'h08);
        check("cfg1_r_w", bus.i2c_r_w, 0);
        wait_cfg(200, ok);
        check("config_done", ok, 1);
        check("accel_before_pulse", $unsigned(accel_x), 0);
        wait_valid(1000, ok);
        check("first_sample_seen", ok, 1);
        check("first_x", $unsigned(accel_x), 16'h1234);
        check("first_y", $unsigned(accel_y), 16'hFFFF);
        check("first_z", $unsigned(accel_z), 16'h0100);

        // Table of sample patterns at a 100-cycle period without overrun
        delay_cfg = 5;
        do_reset(1);
        wait_cfg(300, ok);
        check("b_config_done", ok, 1);
        base = slog.size();
        for (int i = 0; i < 4; i++) begin
            load_mem(vecs[i].bytes);
            wait_valid(300, ok);
            check($sformatf("vec%0d_valid", i), ok, 1);
            check($sformatf("vec%0d_x", i), $unsigned(accel_x), vecs[i].x);
            check($sformatf("vec%0d_y", i), $unsigned(accel_y), vecs[i].y);
            check($sformatf("vec%0d_z", i), $unsigned(accel_z), vecs[i].z);
        end
        check("b_overrun", overrun, 0);
        n32 = 0; bad = 0; last = 0;
        for (int j = base; j < slog.size(); j++) begin
            if (slog[j].rg == 8'h32) begin
                if (n32 > 0 && slog[j].cyc - last != 100) bad++;
                last = slog[j].cyc;
                n32++;
            end
        end
        check("period_read_count", n32, 4);
        check("period_bad_gaps", bad, 0);

        // Reads longer than one period: overrun and immediate restart
        delay_cfg = 25;
        do_reset(1);
        load_mem(vecs[3].bytes);
        wait_valid(1000, ok);
        check("d_sample_seen", ok, 1);
        check("d_overrun", overrun, 1);
        check("d_x", $unsigned(accel_x), 16'h0201);
        ok = 0; n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.i2c_start) begin ok = 1; break; end
            n++;
        end
        check("d_restart_within_2", ok && n < 2, 1);
        check("d_restart_reg", bus.i2c_reg_addr, 8'h32);

        // Timeout: one dropped start retried, then a controller that never answers
        delay_cfg = 5;
        do_reset(1);
        ign_reg = 8'h34; ign_limit = ign_done + 1;
        load_mem(vecs[1].bytes);
        base = slog.size();
        wait_valid(1000, ok);
        check("c_sample_seen", ok, 1);
        check("c_0x34_starts", count_reg(base, 8'h34), 2);
        check("c_x", $unsigned(accel_x), 16'h8000);
        check("c_y", $unsigned(accel_y), 16'h7FFF);
        check("c_z", $unsigned(accel_z), 16'h0001);
        check("c_error_clear", error, 0);
        ign_limit = 1 << 30;
        base = slog.size();
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (error) begin ok = 1; break; end
        end
        check("c_error_set", ok, 1);
        sz = slog.size();
        repeat (300) tick();
        check("c_0x34_retries", count_reg(base, 8'h34), 3);
        check("c_starts_total", slog.size() - base, 5);
        check("c_no_start_after_error", slog.size() - sz, 0);
        check("c_error_sticky", error, 1);

        // Reset mid-read with a busy controller and a pre-held finished level
        ign_limit = ign_done;
        do_reset(1);
        load_mem(vecs[2].bytes);
        wait_valid(1000, ok);
        check("e_sample_seen", ok, 1);
        check("e_x", $unsigned(accel_x), 16'hA55A);
        base = slog.size();
        wait_logged(base, 8'h33, 300, ok);
        check("e_mid_read", ok, 1);
        force_busy = 1;
        do_reset(0);
        check("e_rst_accel_x", $unsigned(accel_x), 0);
        check("e_rst_accel_z", $unsigned(accel_z), 0);
        check("e_rst_config_done", config_done, 0);
        check("e_rst_start", bus.i2c_start, 0);
        check("e_rst_reg", bus.i2c_reg_addr, 0);
        check("e_rst_r_w", bus.i2c_r_w, 0);
        base = slog.size();
        ign_reg = 8'h31; ign_limit = ign_done + 1;
        repeat (60) tick();
        check("e_no_start_while_busy", slog.size() - base, 0);
        force_busy = 0;
        wait_cfg(600, ok);
        check("e_config_done", ok, 1);
        check("e_first_reg", log_reg(base), 8'h31);
        check("e_pre_held_fin", log_fin(base), 1);
        check("e_retry_reg", log_reg(base + 1), 8'h31);
        check("e_second_cfg_reg", log_reg(base + 2), 8'h2D);

        // enable dropped mid-sequence: current sample publishes, no new read
        ign_limit = ign_done;
        base = slog.size();
        wait_logged(base, 8'h33, 300, ok);
        check("e_seq_started", ok, 1);
        enable = 1'b0;
        wait_valid(300, ok);
        check("e_inflight_publish", ok, 1);
        check("e_inflight_y", $unsigned(accel_y), 16'h0000);
        check("e_inflight_z", $unsigned(accel_z), 16'hFFFE);
        base = slog.size();
        repeat (300) tick();
        check("e_no_read_disabled", count_reg(base, 8'h32), 0);
        enable = 1'b1;
        wait_start(8'h32, 150, ok, n);
        check("e_read_resumes", ok, 1);

        check("accel_change_without_valid", chg_err, 0);
        check("start_pulse_width", pulse_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
